// File: rtl/iobuf_bidir_ctrl.sv
// iobuf_bidir_ctrl: fabric-side direction control for an IOBUF-style bidirectional pad.
// Ports: C/R/CE clocking; TX_* valid/ready source; PAD_O/PAD_I/PAD_T primitive; RX_D/RX_VALID capture; BUSY.
module iobuf_bidir_ctrl #(
   parameter int WIDTH       = 1,
   parameter int TURN_CYCLES = 2
) (
   input  logic             C,
   input  logic             R,
   input  logic             CE,
   input  logic [WIDTH-1:0] TX_D,
   input  logic             TX_VALID,
   input  logic             TX_LAST,
   output logic             TX_READY,
   input  logic [WIDTH-1:0] PAD_O,
   output logic [WIDTH-1:0] PAD_I,
   output logic             PAD_T,
   output logic [WIDTH-1:0] RX_D,
   output logic             RX_VALID,
   output logic             BUSY
);

   typedef enum logic [1:0] {
      S_RX      = 2'd0,
      S_TURN_TX = 2'd1,
      S_TX      = 2'd2,
      S_TURN_RX = 2'd3
   } state_t;

   localparam logic [3:0] TURN_LD = 4'(TURN_CYCLES - 1);

   state_t     state, state_n;
   logic [3:0] cnt, cnt_n;
   logic       accept;

   // These four registers sit next to the pad so they can pack into IOB flops.
   logic [WIDTH-1:0] pad_i_q;
   logic             pad_t_q;
   logic [WIDTH-1:0] rx_d_q;
   logic             rx_valid_q;

   assign accept = TX_VALID & TX_READY & CE;

   always_ff @(posedge C) begin
      if (R) begin
         state <= S_RX;
         cnt   <= 4'd0;
      end else if (CE) begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      unique case (state)
         S_RX: begin
            if (TX_VALID) begin
               state_n = S_TURN_TX;
               cnt_n   = TURN_LD;
            end
         end
         S_TURN_TX: begin
            if (cnt == 4'd0) state_n = S_TX;
            else             cnt_n   = cnt - 4'd1;
         end
         S_TX: begin
            if (accept && TX_LAST) state_n = S_TURN_RX;
         end
         S_TURN_RX: begin
            // The first cycle still drives the last word; the
            // high-Z gap only starts counting once the pad is released.
            if (!pad_t_q)           cnt_n   = TURN_LD;
            else if (cnt == 4'd0)   state_n = S_RX;
            else                    cnt_n   = cnt - 4'd1;
         end
         default: begin
            state_n = S_RX;
            cnt_n   = 4'd0;
         end
      endcase
   end

   always_comb begin
      TX_READY = (state == S_TX);
      BUSY     = (state != S_RX);
   end

   always_ff @(posedge C) begin
      if (R) begin
         pad_i_q    <= '0;
         pad_t_q    <= 1'b1;
         rx_d_q     <= '0;
         rx_valid_q <= 1'b0;
      end else if (CE) begin
         rx_valid_q <= (state == S_RX);
         if (state == S_RX) rx_d_q <= PAD_O;
         if (accept) begin
            pad_i_q <= TX_D;
            pad_t_q <= 1'b0;
         end else if (state == S_TURN_RX) begin
            pad_t_q <= 1'b1;
         end
      end
   end

   assign PAD_I    = pad_i_q;
   assign PAD_T    = pad_t_q;
   assign RX_D     = rx_d_q;
   assign RX_VALID = rx_valid_q;

endmodule
